// File: rtl/zjh_mux_scan.sv
// N-channel, W-bit registered selector with active-low enable and a
// round-robin scan mode that presents each channel for DWELL un-held cycles.
module zjh_mux_scan #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   DateIn,
  input  logic [SELW-1:0]   Sel,
  input  logic              Enable,
  input  logic              Mode,
  input  logic              Hold,
  output logic [W-1:0]      DateOut,
  output logic [SELW-1:0]   Chan,
  output logic              Valid
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CH - 1);

  logic [SELW-1:0] scan_idx;
  logic [CW-1:0]   dwell_cnt;
  logic            sel_legal;
  logic [W-1:0]    man_data;
  logic [W-1:0]    scan_data;

  // An index with no matching channel yields zero, which covers Sel >= CH.
  function automatic logic [W-1:0] pick(input logic [CH*W-1:0] data,
                                        input logic [SELW-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      r = (idx == SELW'(i)) ? data[i*W +: W] : r;
    end
    return r;
  endfunction

  always_comb begin
    sel_legal = ({1'b0, Sel} < (SELW+1)'(CH));
    man_data  = pick(DateIn, Sel);
    scan_data = pick(DateIn, scan_idx);
  end

  // Priority: reset, disable, manual, scan (with Hold gating the step).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DateOut   <= '0;
      Chan      <= '0;
      Valid     <= 1'b0;
      scan_idx  <= '0;
      dwell_cnt <= '0;
    end else if (Enable) begin
      DateOut   <= '0;
      Chan      <= '0;
      Valid     <= 1'b0;
      scan_idx  <= '0;
      dwell_cnt <= '0;
    end else if (!Mode) begin
      DateOut   <= man_data;
      Chan      <= Sel;
      Valid     <= sel_legal;
      scan_idx  <= '0;
      dwell_cnt <= '0;
    end else begin
      DateOut <= scan_data;
      Chan    <= scan_idx;
      Valid   <= 1'b1;
      if (!Hold) begin
        if (dwell_cnt == LAST_CNT) begin
          dwell_cnt <= '0;
          scan_idx  <= (scan_idx == LAST_CH) ? '0 : scan_idx + SELW'(1);
        end else begin
          dwell_cnt <= dwell_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_zjh_mux_scan.sv
// Scoreboard bench: two instances (CH=4/W=8/DWELL=4 and CH=3/W=4/DWELL=1)
// checked against a position-count model of the scan schedule.
module tb_zjh_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_din;
  logic [1:0]  a_sel;
  logic        a_en, a_mode, a_hold;
  logic [7:0]  a_out;
  logic [1:0]  a_chan;
  logic        a_valid;
  logic [11:0] b_din;
  logic [1:0]  b_sel;
  logic        b_en, b_mode, b_hold;
  logic [3:0]  b_out;
  logic [1:0]  b_chan;
  logic        b_valid;

  zjh_mux_scan #(.CH(4), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .DateIn(a_din), .Sel(a_sel), .Enable(a_en),
    .Mode(a_mode), .Hold(a_hold), .DateOut(a_out), .Chan(a_chan), .Valid(a_valid)
  );

  zjh_mux_scan #(.CH(3), .W(4), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .DateIn(b_din), .Sel(b_sel), .Enable(b_en),
    .Mode(b_mode), .Hold(b_hold), .DateOut(b_out), .Chan(b_chan), .Valid(b_valid)
  );

  typedef struct {
    logic [7:0] d;
    int         c;
    logic       v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   ka = 0;
  int   kb = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // k counts enabled, un-held scan edges since the scan (re)started.
  task automatic model(input int nch, input int w, input int dwell,
                       input logic r, input logic en, input logic mode,
                       input logic hold, input int sel, input logic [31:0] din,
                       inout int k, output exp_t e);
    int          ch;
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    e.d = 8'd0;
    e.c = 0;
    e.v = 1'b0;
    if (r || en) begin
      k = 0;
    end else if (!mode) begin
      k = 0;
      e.c = sel;
      if (sel < nch) begin
        e.v = 1'b1;
        e.d = 8'((din >> (sel * w)) & mask);
      end
    end else begin
      ch  = (k / dwell) % nch;
      e.c = ch;
      e.v = 1'b1;
      e.d = 8'((din >> (ch * w)) & mask);
      if (!hold) k++;
    end
  endtask

  // Called at a negedge with inputs already applied; the next posedge consumes them.
  task automatic tick();
    exp_t e;
    model(4, 8, 4, rst, a_en, a_mode, a_hold, int'(a_sel), a_din, ka, e);
    qa.push_back(e);
    model(3, 4, 1, rst, b_en, b_mode, b_hold, int'(b_sel), {20'd0, b_din}, kb, e);
    qb.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      n_cmp++;
      if (a_out !== e.d || int'(a_chan) != e.c || a_valid !== e.v) begin
        n_bad++;
        $display("FAIL dut_a got d=%h c=%0d v=%b want d=%h c=%0d v=%b at %0t",
                 a_out, a_chan, a_valid, e.d, e.c, e.v, $time);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      n_cmp++;
      if ({4'd0, b_out} !== e.d || int'(b_chan) != e.c || b_valid !== e.v) begin
        n_bad++;
        $display("FAIL dut_b got d=%h c=%0d v=%b want d=%h c=%0d v=%b at %0t",
                 b_out, b_chan, b_valid, e.d, e.c, e.v, $time);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_din = 32'h0; a_sel = 2'd0; a_en = 1'b1; a_mode = 1'b0; a_hold = 1'b0;
    b_din = 12'h0; b_sel = 2'd0; b_en = 1'b1; b_mode = 1'b0; b_hold = 1'b0;
    @(negedge clk);
    check("reset_a", {a_out, 6'd0, a_chan, 7'd0, a_valid}, 32'd0);
    check("reset_b", {b_out, 6'd0, b_chan, 7'd0, b_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Scan stream, then async reset mid-dwell, then disabled with all-ones data.
    a_en = 1'b0; a_mode = 1'b1; a_din = 32'hDEADBEEF;
    b_en = 1'b0; b_mode = 1'b1; b_din = 12'hA5C;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("async_rst_a", {a_out, 6'd0, a_chan, 7'd0, a_valid}, 32'd0);
    check("async_rst_b", {b_out, 6'd0, b_chan, 7'd0, b_valid}, 32'd0);
    tick();
    rst = 1'b0; a_en = 1'b1; b_en = 1'b1;
    a_din = 32'hFFFFFFFF; b_din = 12'hFFF;
    repeat (5) tick();

    // Manual select on dut_a.
    a_en = 1'b0; a_mode = 1'b0; a_din = 32'h44332211;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      tick();
    end

    // Scan cadence from manual: 17 edges.
    a_mode = 1'b1;
    repeat (17) tick();

    // Hold for 3 cycles at the 2nd cycle of channel 1.
    a_mode = 1'b0; tick();
    a_mode = 1'b1;
    repeat (5) tick();
    a_hold = 1'b1;
    repeat (3) tick();
    a_hold = 1'b0;
    repeat (8) tick();

    // dut_b: scan 0,1,2,0 then illegal manual select, then back to scan.
    b_en = 1'b0; b_mode = 1'b0; b_sel = 2'd0; b_din = 12'h987; tick();
    b_mode = 1'b1;
    repeat (4) tick();
    b_mode = 1'b0; b_sel = 2'd3; tick();
    b_mode = 1'b1; repeat (2) tick();

    // Randomized traffic on both instances.
    for (int i = 0; i < 500; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      a_en   = ($urandom_range(0, 19) == 0);
      a_mode = ($urandom_range(0, 3) != 0);
      a_hold = ($urandom_range(0, 3) == 0);
      a_sel  = 2'($urandom_range(0, 3));
      a_din  = $urandom;
      b_en   = ($urandom_range(0, 19) == 0);
      b_mode = ($urandom_range(0, 3) != 0);
      b_hold = ($urandom_range(0, 3) == 0);
      b_sel  = 2'($urandom_range(0, 3));
      b_din  = 12'($urandom);
      tick();
    end
    rst = 1'b0;

    @(posedge clk);
    #2;
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
